// File: rtl/store_buffer_dmem.sv
// Memory-stage data RAM behind a small in-order store buffer.
// Stores retire into the buffer, drain to RAM on load-free cycles, and loads forward from the youngest match.
module store_buffer_dmem #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    input  logic [31:0]              A,
    input  logic [31:0]              WD,
    output logic [31:0]              RD,
    output logic                     Stall,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(MEM_WORDS);

    logic [IW-1:0]    widx_q [DEPTH];
    logic [IW-1:0]    widx_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      mem_q [MEM_WORDS];

    logic [IW-1:0]    widx;
    logic             full;
    logic             do_store;
    logic             do_drain;
    logic             hit;
    logic [31:0]      fwd;
    logic [PW-1:0]    idx;
    logic             unused_addr;

    assign widx        = A[IW+1:2];
    assign unused_addr = ^{A[31:IW+2], A[1:0]};
    assign full        = (count_q == CW'(DEPTH));
    assign do_store    = MemWrite && !full;
    // A load owns the RAM port; a store-only cycle (even with MemRead) still blocks draining
    assign do_drain    = (count_q != '0) && !MemRead;

    always_comb begin
        widx_d  = widx_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_store) begin
            widx_d[tail_q]  = widx;
            data_d[tail_q]  = WD;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        if (do_drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        case ({do_store, do_drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match seen is the youngest store
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (widx_q[idx] == widx)) begin
                hit = 1'b1;
                fwd = data_q[idx];
            end
        end
    end

    assign RD    = (MemRead && !MemWrite) ? (hit ? fwd : mem_q[widx]) : '0;
    assign Stall = MemWrite && full;
    assign Empty = (count_q == '0);
    assign Count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        widx_q <= widx_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (!reset && do_drain) begin
            mem_q[widx_q[head_q]] <= data_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= CW'(DEPTH));
            assert ((count_q == '0) == Empty);
            if (full) begin
                assert (Stall == MemWrite);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer_dmem.sv
// Self-checking bench for store_buffer_dmem: queue/array reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer_dmem;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic        Stall;
    logic        Empty;
    logic [2:0]  Count;

    int tests = 0;
    int fails = 0;

    store_buffer_dmem #(.DEPTH(DEPTH), .MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .A(A), .WD(WD), .RD(RD), .Stall(Stall), .Empty(Empty), .Count(Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [31:0] d;
    } entry_t;

    entry_t      sbq[$];
    logic [31:0] mem_m [64];
    bit          known [64];
    bit          chk_en = 1'b0;
    bit          st, dr;
    bit          rd_known;
    logic [31:0] rd_exp;
    int          n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) known[i] = 1'b0;
    end

    // Reference model: a plain FIFO of {word, data} plus an array for RAM
    always @(posedge clk) begin
        if (reset) begin
            sbq.delete();
            chk_en = 1'b1;
        end else begin
            st = MemWrite && (sbq.size() < DEPTH);
            dr = (sbq.size() > 0) && !MemRead;
            if (dr) begin
                mem_m[sbq[0].w] = sbq[0].d;
                known[sbq[0].w] = 1'b1;
                void'(sbq.pop_front());
            end
            if (st) sbq.push_back('{w: int'(A[7:2]), d: WD});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n = sbq.size();
            check("model_count", 32'(Count), 32'(n));
            check("model_empty", 32'(Empty), 32'(n == 0));
            check("model_stall", 32'(Stall), 32'(MemWrite && n == DEPTH));
            rd_exp   = '0;
            rd_known = 1'b1;
            if (MemRead && !MemWrite) begin
                rd_known = known[A[7:2]];
                rd_exp   = mem_m[A[7:2]];
                for (int i = 0; i < n; i++) begin
                    if (sbq[i].w == int'(A[7:2])) begin
                        rd_exp   = sbq[i].d;
                        rd_known = 1'b1;
                    end
                end
            end
            if (rd_known) check("model_rd", RD, rd_exp);
        end
    end

    task automatic set_in(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd);
        MemWrite = we;
        MemRead  = re;
        A        = a;
        WD       = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        set_in(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 32'h0);
        check("reset_count", 32'(Count), 32'd0);
        check("reset_empty", 32'(Empty), 32'd1);
        check("reset_stall", 32'(Stall), 32'd0);
        check("reset_rd", RD, 32'd0);

        // forwarding, then drain to RAM
        set_in(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        tick();
        set_in(1'b0, 1'b1, 32'h10, 32'h0);
        check("t1_fwd_rd", RD, 32'hDEADBEEF);
        check("t1_count", 32'(Count), 32'd1);
        tick();
        idle(1);
        check("t1_empty", 32'(Empty), 32'd1);
        set_in(1'b0, 1'b1, 32'h10, 32'h0);
        check("t1_ram_rd", RD, 32'hDEADBEEF);
        tick();

        // fill to DEPTH, stall, then release
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'(100 + i));
            tick();
        end
        set_in(1'b1, 1'b1, 32'h50, 32'h200);
        check("t2_stall", 32'(Stall), 32'd1);
        check("t2_full_count", 32'(Count), 32'd4);
        check("t2_st_ld_rd", RD, 32'd0);
        tick();
        check("t2_count_held", 32'(Count), 32'd4);
        set_in(1'b1, 1'b0, 32'h50, 32'h200);
        check("t2_stall_no_reuse", 32'(Stall), 32'd1);
        tick();
        check("t2_count_after_drain", 32'(Count), 32'd3);
        check("t2_stall_released", 32'(Stall), 32'd0);
        tick();
        check("t2_count_accept", 32'(Count), 32'd3);
        idle(4);
        check("t2_empty", 32'(Empty), 32'd1);
        set_in(1'b0, 1'b1, 32'h50, 32'h0);
        check("t2_fifth_in_ram", RD, 32'h200);
        set_in(1'b0, 1'b1, 32'h4C, 32'h0);
        check("t2_fourth_in_ram", RD, 32'd103);
        tick();

        // youngest of two same-address stores wins
        set_in(1'b1, 1'b1, 32'h20, 32'd1);
        tick();
        set_in(1'b1, 1'b1, 32'h20, 32'd2);
        tick();
        set_in(1'b0, 1'b1, 32'h20, 32'h0);
        check("t3_youngest_fwd", RD, 32'd2);
        check("t3_count", 32'(Count), 32'd2);
        tick();
        idle(3);
        set_in(1'b0, 1'b1, 32'h20, 32'h0);
        check("t3_last_wins_ram", RD, 32'd2);
        tick();

        // miss path with a non-matching entry buffered
        set_in(1'b1, 1'b0, 32'h20, 32'h55);
        tick();
        idle(1);
        set_in(1'b1, 1'b1, 32'h24, 32'h77);
        tick();
        set_in(1'b0, 1'b1, 32'h20, 32'h0);
        check("t4_miss_rd", RD, 32'h55);
        check("t4_count", 32'(Count), 32'd1);
        set_in(1'b0, 1'b1, 32'h24, 32'h0);
        check("t4_hit_rd", RD, 32'h77);
        set_in(1'b0, 1'b1, 32'h124, 32'h0);
        check("t4_alias_hit_rd", RD, 32'h77);
        tick();
        idle(2);

        // reset mid-drain discards pending stores
        set_in(1'b1, 1'b0, 32'h64, 32'h11);
        tick();
        set_in(1'b1, 1'b0, 32'h68, 32'h22);
        tick();
        idle(3);
        set_in(1'b1, 1'b1, 32'h60, 32'hA0);
        tick();
        set_in(1'b1, 1'b1, 32'h64, 32'hA1);
        tick();
        set_in(1'b1, 1'b1, 32'h68, 32'hA2);
        tick();
        idle(1);
        check("t5_count_mid", 32'(Count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 32'h0);
        check("t5_count_reset", 32'(Count), 32'd0);
        check("t5_empty_reset", 32'(Empty), 32'd1);
        set_in(1'b0, 1'b1, 32'h60, 32'h0);
        check("t5_drained_rd", RD, 32'hA0);
        set_in(1'b0, 1'b1, 32'h64, 32'h0);
        check("t5_old_rd_64", RD, 32'h11);
        set_in(1'b0, 1'b1, 32'h68, 32'h0);
        check("t5_old_rd_68", RD, 32'h22);
        tick();

        // steady store+drain with pointer wrap
        set_in(1'b1, 1'b1, 32'h80, 32'hB0);
        tick();
        set_in(1'b1, 1'b1, 32'h84, 32'hB1);
        tick();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b0, 32'h80 + 32'(4 * (i % 3)), 32'h1000 + 32'(i));
            tick();
            check("t6_count_steady", 32'(Count), 32'd2);
        end
        idle(2);
        check("t6_empty", 32'(Empty), 32'd1);
        set_in(1'b0, 1'b1, 32'h80, 32'h0);
        check("t6_rd_80", RD, 32'h1003);
        set_in(1'b0, 1'b1, 32'h84, 32'h0);
        check("t6_rd_84", RD, 32'h1004);
        set_in(1'b0, 1'b1, 32'h88, 32'h0);
        check("t6_rd_88", RD, 32'h1005);
        tick();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
